// File: rtl/axi4bus_pkg.sv
// Shared AXI4 read-path definitions: AR/R bundle layout, response codes,
// default-responder FSM states and an R-bundle packing helper.
package axi4bus_pkg;

    localparam int AR_W        = 77;
    localparam int R_W         = 75;

    localparam int AR_LEN_LSB  = 69;
    localparam int AR_LEN_W    = 8;
    localparam int AR_ADDR_LSB = 33;
    localparam int AR_ADDR_W   = 36;
    localparam int AR_ID_LSB   = 25;
    localparam int AR_ID_W     = 8;

    localparam int R_ID_LSB    = 67;
    localparam int R_ID_W      = 8;
    localparam int R_DATA_LSB  = 3;
    localparam int R_DATA_W    = 64;
    localparam int R_RESP_LSB  = 1;
    localparam int R_RESP_W    = 2;
    localparam int R_LAST_BIT  = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    function automatic logic [R_W-1:0] r_pack(
        input logic [R_ID_W-1:0]   id,
        input logic [R_DATA_W-1:0] data,
        input logic [R_RESP_W-1:0] resp,
        input logic                last
    );
        return {id, data, resp, last};
    endfunction

endpackage

// File: rtl/r_default_responder.sv
// Default AXI4 read slave: answers every unmapped AR with a full DECERR burst.
// Optional completed-burst counter output ERRCNT under `RDEFAULT_ERRCNT_EN`.
module r_default_responder
    import axi4bus_pkg::*;
#(
    parameter logic [63:0] DATA_FILL = 64'h0000000000000000,
    parameter logic [1:0]  RESP_CODE = 2'b11
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [76:0]   DATAi,
    input  logic          VALIDi,
    output logic          READYi,
    output logic [74:0]   DATAo,
    output logic          VALIDo,
`ifdef RDEFAULT_ERRCNT_EN
    output logic [15:0]   ERRCNT,
`endif
    input  logic          READYo
);

    rd_state_e        state_q, state_d;
    logic [7:0]       id_q, id_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       beat_q, beat_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [R_W-1:0]   data_q, data_d;
    logic [7:0]       beat_inc_s;
    logic [7:0]       ar_id_s;
    logic [7:0]       ar_len_s;
    logic             hs_last_s;
    logic             unused_ar_s;

    assign ar_id_s    = DATAi[AR_ID_LSB +: AR_ID_W];
    assign ar_len_s   = DATAi[AR_LEN_LSB +: AR_LEN_W];
    assign beat_inc_s = beat_q + 8'd1;
    assign unused_ar_s = ^{DATAi[AR_ADDR_LSB +: AR_ADDR_W], DATAi[AR_ID_LSB-1:0]};

    // Next-state, beat counter and registered R-channel outputs.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        data_d    = data_q;
        hs_last_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (VALIDi && ready_q) begin
                    state_d = ST_BURST;
                    id_d    = ar_id_s;
                    len_d   = ar_len_s;
                    beat_d  = 8'd0;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    data_d  = r_pack(ar_id_s, DATA_FILL, RESP_CODE, ar_len_s == 8'd0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (valid_q && READYo) begin
                    if (data_q[R_LAST_BIT]) begin
                        // Counter is cleared rather than incremented so LEN=255 never wraps.
                        hs_last_s = 1'b1;
                        state_d   = ST_IDLE;
                        beat_d    = 8'd0;
                        valid_d   = 1'b0;
                        ready_d   = 1'b1;
                        data_d    = {R_W{1'b0}};
                    end else begin
                        beat_d = beat_inc_s;
                        data_d = r_pack(id_q, DATA_FILL, RESP_CODE, beat_inc_s == len_q);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 8'd0;
                valid_d = 1'b0;
                ready_d = 1'b1;
                data_d  = {R_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            id_q    <= 8'd0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= {R_W{1'b0}};
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign READYi = ready_q;
    assign VALIDo = valid_q;
    assign DATAo  = data_q;

`ifdef RDEFAULT_ERRCNT_EN
    logic [15:0] errcnt_q, errcnt_d;

    // Saturating count of completed DECERR bursts.
    always_comb begin
        errcnt_d = errcnt_q;
        if (hs_last_s && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'd1;
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            errcnt_q <= 16'd0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign ERRCNT = errcnt_q;
`else
    logic unused_hs_s;
    assign unused_hs_s = hs_last_s;
`endif

endmodule

// File: tb/tb_r_default_responder.sv
// Directed self-checking bench for r_default_responder (ERRCNT checked when
// RDEFAULT_ERRCNT_EN is defined).
module tb_r_default_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [76:0] datai;
    logic        validi;
    logic        readyi;
    logic [74:0] datao;
    logic        valido;
    logic        readyo;
`ifdef RDEFAULT_ERRCNT_EN
    logic [15:0] errcnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    r_default_responder dut (
        .CLK    (clk),
        .RST    (rst),
        .DATAi  (datai),
        .VALIDi (validi),
        .READYi (readyi),
        .DATAo  (datao),
        .VALIDo (valido),
`ifdef RDEFAULT_ERRCNT_EN
        .ERRCNT (errcnt),
`endif
        .READYo (readyo)
    );

    function automatic logic [76:0] mk_ar(input logic [7:0] id, input logic [7:0] len);
        logic [76:0] v;
        v = {8'h00, 36'hA_5A5A_C3C3, 8'h00, 25'h1_55AA_F3};
        v[76:69] = len;
        v[32:25] = id;
        return v;
    endfunction

    function automatic logic [74:0] exp_r(input logic [7:0] id, input logic last);
        return {id, 64'h0000000000000000, 2'b11, last};
    endfunction

    task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one AR and drains its burst with READYo either held high or toggling 1,0,1,...
    task automatic run_burst(input logic [7:0] id, input logic [7:0] len, input bit toggle);
        int beats;
        int budget;
        int exp_beats;
        exp_beats = int'(len) + 1;
        datai  = mk_ar(id, len);
        validi = 1'b1;
        readyo = 1'b1;
        check("ar_ready_idle", {74'd0, readyi}, 75'd1);
        step();
        validi = 1'b0;
        beats  = 0;
        budget = 0;
        while (beats < exp_beats && budget < 700) begin
            readyo = toggle ? ((budget % 2) == 0) : 1'b1;
            check("burst_valid", {74'd0, valido}, 75'd1);
            check("burst_ar_blocked", {74'd0, readyi}, 75'd0);
            check("burst_beat", datao, exp_r(id, beats == exp_beats - 1));
            if (readyo && valido) beats++;
            budget++;
            step();
        end
        check("burst_beat_count", 75'(beats), 75'(exp_beats));
        readyo = 1'b0;
        check("post_burst_valid", {74'd0, valido}, 75'd0);
        check("post_burst_ready", {74'd0, readyi}, 75'd1);
    endtask

    initial begin
        rst    = 1'b1;
        datai  = 77'd0;
        validi = 1'b0;
        readyo = 1'b0;
        #12;
        check("rst_readyi", {74'd0, readyi}, 75'd1);
        check("rst_valido", {74'd0, valido}, 75'd0);
        check("rst_datao", datao, 75'd0);
`ifdef RDEFAULT_ERRCNT_EN
        check("rst_errcnt", {59'd0, errcnt}, 75'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_readyi", {74'd0, readyi}, 75'd1);
        check("idle_valido", {74'd0, valido}, 75'd0);

        // Single-beat burst, latency N+1 and READYi back in N+2.
        datai  = mk_ar(8'h5A, 8'd0);
        validi = 1'b1;
        readyo = 1'b1;
        step();
        validi = 1'b0;
        check("len0_valid", {74'd0, valido}, 75'd1);
        check("len0_ready", {74'd0, readyi}, 75'd0);
        check("len0_beat", datao, exp_r(8'h5A, 1'b1));
        step();
        check("len0_readyi_back", {74'd0, readyi}, 75'd1);
        check("len0_valid_low", {74'd0, valido}, 75'd0);

        // Four beats with stalls; expected beat is compared every cycle, so stalls must hold DATAo.
        run_burst(8'h07, 8'd3, 1'b1);

        // Longest burst: LAST only on beat 256.
        run_burst(8'hC9, 8'd255, 1'b0);

        // Back-to-back ARs: second is held off until after the first LAST handshake.
        datai  = mk_ar(8'h01, 8'd1);
        validi = 1'b1;
        readyo = 1'b1;
        step();
        datai  = mk_ar(8'h02, 8'd0);
        check("b2b_beat0", datao, exp_r(8'h01, 1'b0));
        check("b2b_blocked0", {74'd0, readyi}, 75'd0);
        step();
        check("b2b_beat1", datao, exp_r(8'h01, 1'b1));
        check("b2b_blocked1", {74'd0, readyi}, 75'd0);
        step();
        check("b2b_ready_after_last", {74'd0, readyi}, 75'd1);
        check("b2b_gap_valid", {74'd0, valido}, 75'd0);
        step();
        validi = 1'b0;
        check("b2b_second_beat", datao, exp_r(8'h02, 1'b1));
        check("b2b_second_valid", {74'd0, valido}, 75'd1);
        step();
        check("b2b_done", {74'd0, valido}, 75'd0);

        // Reset on beat 2 of an 8-beat burst.
        datai  = mk_ar(8'h33, 8'd7);
        validi = 1'b1;
        readyo = 1'b1;
        step();
        validi = 1'b0;
        step();
        step();
        check("rst_mid_beat2", datao, exp_r(8'h33, 1'b0));
        rst = 1'b1;
        #1;
        check("rst_mid_valido", {74'd0, valido}, 75'd0);
        check("rst_mid_readyi", {74'd0, readyi}, 75'd1);
        check("rst_mid_datao", datao, 75'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_burst(8'h44, 8'd1, 1'b0);
`ifdef RDEFAULT_ERRCNT_EN
        check("errcnt_completed", {59'd0, errcnt}, 75'd1);
`endif

        // Completed bursts since the mid-burst reset: one (errcnt was cleared by that reset).
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
